// File: rtl/fpcvt_pkg.sv
// fpcvt_pkg: shared defaults, width relation and result word layout
// for the linear-to-float converter pipeline.
package fpcvt_pkg;

    localparam int EXP_W_DEF  = 3;
    localparam int MANT_W_DEF = 4;

    // Input width is tied to the format so the largest normalised
    // exponent lands exactly on the all-ones code.
    function automatic int data_w(input int exp_w, input int mant_w);
        return mant_w + (1 << exp_w);
    endfunction

    typedef struct packed {
        logic                  s;
        logic [EXP_W_DEF-1:0]  e;
        logic [MANT_W_DEF-1:0] f;
        logic                  sat;
        logic                  inexact;
    } fp_res_t;

endpackage

// File: rtl/fpcvt_lzc.sv
// fpcvt_lzc: combinational leading-one detector returning the index
// of the highest set bit and a nonzero flag.
module fpcvt_lzc #(
    parameter int W  = 11,
    parameter int PW = $clog2(W)
) (
    input  logic [W-1:0]  vec_i,
    output logic [PW-1:0] pos_o,
    output logic          nz_o
);

    always_comb begin
        pos_o = '0;
        for (int i = 0; i < W; i++) begin
            if (vec_i[i]) pos_o = PW'(i);
        end
    end

    assign nz_o = |vec_i;

endmodule

// File: rtl/fpcvt_pipe.sv
// fpcvt_pipe: 3-stage two's-complement to sign/exponent/mantissa converter
// with valid/ready backpressure, optional half-up rounding and saturation.
module fpcvt_pipe
    import fpcvt_pkg::*;
#(
    parameter int EXP_W    = EXP_W_DEF,
    parameter int MANT_W   = MANT_W_DEF,
    parameter int DATA_W   = data_w(EXP_W, MANT_W),
    parameter bit ROUND_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_s,
    output logic [EXP_W-1:0]  out_e,
    output logic [MANT_W-1:0] out_f,
    output logic              out_sat,
    output logic              out_inexact
);

    localparam int MW = DATA_W - 1;
    localparam int PW = $clog2(MW);

    if (DATA_W != data_w(EXP_W, MANT_W) || EXP_W < 2 || MANT_W < 2) begin : g_cfg_chk
        $error("fpcvt_pipe: need DATA_W == MANT_W + 2**EXP_W, EXP_W >= 2, MANT_W >= 2");
    end

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // S1: sign-magnitude; the top magnitude bit only survives for the
    // most-negative input, which cannot be represented and must saturate.
    logic [DATA_W-1:0] abs_d;
    logic              v1_q, s1_q, fs1_q;
    logic [MW-1:0]     mag1_q;

    assign abs_d = in_data[DATA_W-1] ? -in_data : in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            s1_q   <= 1'b0;
            fs1_q  <= 1'b0;
            mag1_q <= '0;
        end else if (en) begin
            v1_q   <= in_valid;
            s1_q   <= in_data[DATA_W-1];
            fs1_q  <= abs_d[DATA_W-1];
            mag1_q <= abs_d[MW-1:0];
        end
    end

    // S2: normalise by left-aligning the leading one at bit MW-1.
    logic [PW-1:0]     p2, sh_amt;
    logic              nz2;
    logic [MW-1:0]     norm;
    logic [EXP_W-1:0]  e2_d, e2_q;
    logic [MANT_W-1:0] f2_d, f2_q;
    logic              r2_d, st2_d;
    logic              v2_q, s2_q, r2_q, st2_q, fs2_q;

    fpcvt_lzc #(.W(MW), .PW(PW)) u_lzc (
        .vec_i (mag1_q),
        .pos_o (p2),
        .nz_o  (nz2)
    );

    assign sh_amt = PW'(MW - 1) - p2;
    assign norm   = mag1_q << sh_amt;

    always_comb begin
        if (!nz2 || 32'(p2) < MANT_W) begin
            e2_d  = '0;
            f2_d  = mag1_q[MANT_W-1:0];
            r2_d  = 1'b0;
            st2_d = 1'b0;
        end else begin
            e2_d  = EXP_W'(32'(p2) - (MANT_W - 1));
            f2_d  = norm[MW-1 -: MANT_W];
            r2_d  = norm[MW-1-MANT_W];
            st2_d = |norm[MW-2-MANT_W:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q  <= 1'b0;
            s2_q  <= 1'b0;
            e2_q  <= '0;
            f2_q  <= '0;
            r2_q  <= 1'b0;
            st2_q <= 1'b0;
            fs2_q <= 1'b0;
        end else if (en) begin
            v2_q  <= v1_q;
            s2_q  <= s1_q;
            e2_q  <= e2_d;
            f2_q  <= f2_d;
            r2_q  <= r2_d;
            st2_q <= st2_d;
            fs2_q <= fs1_q;
        end
    end

    // S3: round, renormalise on mantissa carry, then clamp.
    logic              rnd;
    logic [MANT_W:0]   fr;
    logic [EXP_W:0]    er;
    logic              sat3_d;
    logic [EXP_W-1:0]  e3_d;
    logic [MANT_W-1:0] f3_d;

    assign rnd    = ROUND_EN && r2_q;
    assign fr     = {1'b0, f2_q} + (MANT_W+1)'(rnd);
    assign er     = {1'b0, e2_q} + (EXP_W+1)'(fr[MANT_W]);
    assign sat3_d = er[EXP_W] || fs2_q;

    always_comb begin
        e3_d = er[EXP_W-1:0];
        f3_d = fr[MANT_W] ? fr[MANT_W:1] : fr[MANT_W-1:0];
        if (sat3_d) begin
            e3_d = '1;
            f3_d = '1;
        end
    end

    logic              ov_q, os_q, osat_q, oinx_q;
    logic [EXP_W-1:0]  oe_q;
    logic [MANT_W-1:0] of_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q   <= 1'b0;
            os_q   <= 1'b0;
            oe_q   <= '0;
            of_q   <= '0;
            osat_q <= 1'b0;
            oinx_q <= 1'b0;
        end else if (en) begin
            ov_q   <= v2_q;
            os_q   <= s2_q;
            oe_q   <= e3_d;
            of_q   <= f3_d;
            osat_q <= sat3_d;
            oinx_q <= r2_q | st2_q | sat3_d;
        end
    end

    assign out_valid   = ov_q;
    assign out_s       = os_q;
    assign out_e       = oe_q;
    assign out_f       = of_q;
    assign out_sat     = osat_q;
    assign out_inexact = oinx_q;

endmodule

// File: tb/tb_fpcvt_pipe.sv
// tb_fpcvt_pipe: self-checking bench for fpcvt_pipe in three configurations
// against an arithmetic reference model of the conversion.
module tb_fpcvt_pipe;
    import fpcvt_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;

    // default instance
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [11:0] in_data = '0;
    logic        out_s, out_sat, out_inexact;
    logic [2:0]  out_e;
    logic [3:0]  out_f;

    fpcvt_pipe u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_e(out_e), .out_f(out_f),
        .out_sat(out_sat), .out_inexact(out_inexact)
    );

    // truncating instance
    logic        t_iv = 1'b0, t_ir, t_ov, t_or = 1'b1;
    logic [11:0] t_d = '0;
    logic        t_s, t_sat, t_inx;
    logic [2:0]  t_e;
    logic [3:0]  t_f;

    fpcvt_pipe #(.ROUND_EN(1'b0)) u_trunc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(t_iv), .in_ready(t_ir), .in_data(t_d),
        .out_valid(t_ov), .out_ready(t_or),
        .out_s(t_s), .out_e(t_e), .out_f(t_f),
        .out_sat(t_sat), .out_inexact(t_inx)
    );

    // EXP_W=2, MANT_W=5 instance
    logic       p_iv = 1'b0, p_ir, p_ov, p_or = 1'b1;
    logic [8:0] p_d = '0;
    logic       p_s, p_sat, p_inx;
    logic [1:0] p_e;
    logic [4:0] p_f;

    fpcvt_pipe #(.EXP_W(2), .MANT_W(5), .DATA_W(9)) u_p25 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(p_iv), .in_ready(p_ir), .in_data(p_d),
        .out_valid(p_ov), .out_ready(p_or),
        .out_s(p_s), .out_e(p_e), .out_f(p_f),
        .out_sat(p_sat), .out_inexact(p_inx)
    );

    typedef struct {
        bit s;
        int e;
        int f;
        bit sat;
        bit inx;
    } fp_t;

    // Reference: shift the magnitude right until it fits the mantissa;
    // the shift count is the exponent, the dropped part is the remainder.
    function automatic fp_t ref_cvt(input int x, input int ew, input int mw, input bit rnd);
        fp_t r;
        int mag, k, rem, emax;
        r.s = (x < 0);
        mag = (x < 0) ? -x : x;
        k = 0;
        while ((mag >> k) >= (1 << mw)) k++;
        r.f = mag >> k;
        rem = mag - (r.f << k);
        if (rnd && k > 0 && rem >= (1 << (k - 1))) begin
            r.f++;
            if (r.f == (1 << mw)) begin
                r.f = r.f >> 1;
                k++;
            end
        end
        emax = (1 << ew) - 1;
        r.sat = (k > emax);
        r.e = r.sat ? emax : k;
        if (r.sat) r.f = (1 << mw) - 1;
        r.inx = (rem != 0) || r.sat;
        return r;
    endfunction

    function automatic logic [9:0] pk34(input fp_t m);
        return {m.s, 3'(m.e), 4'(m.f), m.sat, m.inx};
    endfunction

    function automatic logic [9:0] pk25(input fp_t m);
        return {m.s, 2'(m.e), 5'(m.f), m.sat, m.inx};
    endfunction

    int         acc_q[$];
    logic [9:0] got_q[$];

    task automatic step(input bit iv, input int x, input bit ordy);
        @(negedge clk);
        in_valid  = iv;
        in_data   = 12'(x);
        out_ready = ordy;
        #1;
        if (in_valid && in_ready) acc_q.push_back(x);
        if (out_valid && out_ready)
            got_q.push_back({out_s, out_e, out_f, out_sat, out_inexact});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nchk++;
        if ({out_valid, t_ov, p_ov, in_ready} !== 4'b0001) begin
            nerr++;
            $display("FAIL reset_handshake got=%b exp=0001", {out_valid, t_ov, p_ov, in_ready});
        end
        nchk++;
        if ({out_s, out_e, out_f, out_sat, out_inexact} !== 10'd0) begin
            nerr++;
            $display("FAIL reset_outputs got=%b exp=0", {out_s, out_e, out_f, out_sat, out_inexact});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        acc_q.delete();
        got_q.delete();
        step(1'b1, 16, 1'b1);
        step(1'b0, 0, 1'b1);
        nchk++;
        if (out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL latency_early got=%b exp=0", out_valid);
        end
        step(1'b0, 0, 1'b1);
        nchk++;
        if ({out_valid, out_s, out_e, out_f, out_sat, out_inexact} !== 11'b1_0_001_1000_0_0) begin
            nerr++;
            $display("FAIL latency_3cyc got=%b exp=%b",
                     {out_valid, out_s, out_e, out_f, out_sat, out_inexact}, 11'b1_0_001_1000_0_0);
        end
        step(1'b0, 0, 1'b1);
    endtask

    task automatic test_directed();
        int         vin[9];
        logic [9:0] vexp[9];
        vin  = '{0, 1, 16, 256, 2047, -2048, -1, 173, 125};
        vexp = '{10'b0_000_0000_0_0, 10'b0_000_0001_0_0, 10'b0_001_1000_0_0,
                 10'b0_101_1000_0_0, 10'b0_111_1111_1_1, 10'b1_111_1111_1_1,
                 10'b1_000_0001_0_0, 10'b0_100_1011_0_1, 10'b0_100_1000_0_1};
        acc_q.delete();
        got_q.delete();
        for (int i = 0; i < 9; i++) step(1'b1, vin[i], 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b1);
        nchk++;
        if (got_q.size() != 9) begin
            nerr++;
            $display("FAIL directed_count got=%0d exp=9", got_q.size());
        end
        for (int i = 0; i < 9 && i < got_q.size(); i++) begin
            nchk++;
            if (got_q[i] !== vexp[i]) begin
                nerr++;
                $display("FAIL directed_%0d in=%0d got=%b exp=%b", i, vin[i], got_q[i], vexp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int         vals[8];
        int         idx, n0;
        bit         ordy, have;
        logic [9:0] snap, cur;
        logic [11:0] r12;
        for (int i = 0; i < 8; i++) begin
            r12 = 12'($urandom);
            vals[i] = int'($signed(r12));
        end
        acc_q.delete();
        got_q.delete();
        idx = 0;
        have = 1'b0;
        snap = '0;
        for (int cyc = 0; cyc < 40 && (idx < 8 || got_q.size() < 8); cyc++) begin
            ordy = !(cyc >= 5 && cyc < 10);
            n0 = acc_q.size();
            step(idx < 8, (idx < 8) ? vals[idx] : 0, ordy);
            if (acc_q.size() != n0) idx++;
            if (!ordy) begin
                cur = {out_s, out_e, out_f, out_sat, out_inexact};
                nchk++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                    nerr++;
                    $display("FAIL stall_hs cyc=%0d got=%b%b exp=10", cyc, out_valid, in_ready);
                end
                if (have) begin
                    nchk++;
                    if (cur !== snap) begin
                        nerr++;
                        $display("FAIL stall_stable cyc=%0d got=%b exp=%b", cyc, cur, snap);
                    end
                end
                snap = cur;
                have = 1'b1;
            end
        end
        nchk++;
        if (got_q.size() != 8 || acc_q.size() != 8) begin
            nerr++;
            $display("FAIL b2b_count got=%0d/%0d exp=8/8", got_q.size(), acc_q.size());
        end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            nchk++;
            if (got_q[i] !== pk34(ref_cvt(vals[i], 3, 4, 1'b1))) begin
                nerr++;
                $display("FAIL b2b_%0d in=%0d got=%b exp=%b", i, vals[i], got_q[i],
                         pk34(ref_cvt(vals[i], 3, 4, 1'b1)));
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] r12;
        int          x;
        acc_q.delete();
        got_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            r12 = 12'($urandom);
            x = int'($signed(r12));
            step($urandom_range(0, 3) != 0, x, $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < 10 && got_q.size() < acc_q.size(); i++) step(1'b0, 0, 1'b1);
        nchk++;
        if (got_q.size() != acc_q.size()) begin
            nerr++;
            $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), acc_q.size());
        end
        for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
            nchk++;
            if (got_q[i] !== pk34(ref_cvt(acc_q[i], 3, 4, 1'b1))) begin
                nerr++;
                $display("FAIL rand_%0d in=%0d got=%b exp=%b", i, acc_q[i], got_q[i],
                         pk34(ref_cvt(acc_q[i], 3, 4, 1'b1)));
            end
        end
    endtask

    task automatic test_mid_reset();
        acc_q.delete();
        got_q.delete();
        step(1'b1, 100, 1'b1);
        step(1'b1, -500, 1'b1);
        step(1'b1, 1000, 1'b1);
        step(1'b1, 7, 1'b1);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        nchk++;
        if ({out_valid, out_s, out_e, out_f, out_sat, out_inexact} !== 11'd0) begin
            nerr++;
            $display("FAIL midreset_clear got=%b exp=0",
                     {out_valid, out_s, out_e, out_f, out_sat, out_inexact});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acc_q.delete();
        got_q.delete();
        for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b1);
        nchk++;
        if (got_q.size() != 0) begin
            nerr++;
            $display("FAIL midreset_stale got=%0d exp=0", got_q.size());
        end
        step(1'b1, -37, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b1);
        nchk++;
        if (got_q.size() != 1 || got_q[0] !== 10'b1_010_1001_0_1) begin
            nerr++;
            $display("FAIL midreset_next n=%0d got=%b exp=%b", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 10'bx, 10'b1_010_1001_0_1);
        end
    endtask

    task automatic test_trunc();
        int          x;
        logic [11:0] r12;
        logic [9:0]  exp_v;
        for (int i = 0; i < 13; i++) begin
            r12 = 12'($urandom);
            x = (i == 0) ? 173 : int'($signed(r12));
            exp_v = pk34(ref_cvt(x, 3, 4, 1'b0));
            @(negedge clk);
            t_iv = 1'b1;
            t_d  = 12'(x);
            @(posedge clk);
            @(negedge clk);
            t_iv = 1'b0;
            @(posedge clk);
            #1;
            nchk++;
            if (t_ov !== 1'b0) begin
                nerr++;
                $display("FAIL trunc_early in=%0d got=%b exp=0", x, t_ov);
            end
            @(posedge clk);
            #1;
            nchk++;
            if (t_ov !== 1'b1 || {t_s, t_e, t_f, t_sat, t_inx} !== exp_v) begin
                nerr++;
                $display("FAIL trunc in=%0d got=%b/%b exp=1/%b", x, t_ov,
                         {t_s, t_e, t_f, t_sat, t_inx}, exp_v);
            end
            if (i == 0) begin
                nchk++;
                if ({t_s, t_e, t_f, t_sat, t_inx} !== 10'b0_100_1010_0_1) begin
                    nerr++;
                    $display("FAIL trunc_173 got=%b exp=%b", {t_s, t_e, t_f, t_sat, t_inx},
                             10'b0_100_1010_0_1);
                end
            end
        end
    endtask

    task automatic test_param();
        int         x;
        logic [8:0] r9;
        logic [9:0] exp_v;
        for (int i = 0; i < 14; i++) begin
            r9 = 9'($urandom);
            x = (i == 0) ? 255 : (i == 1) ? -37 : int'($signed(r9));
            exp_v = (i == 0) ? 10'b0_11_11111_1_1 :
                    (i == 1) ? 10'b1_01_10011_0_1 : pk25(ref_cvt(x, 2, 5, 1'b1));
            @(negedge clk);
            p_iv = 1'b1;
            p_d  = 9'(x);
            @(posedge clk);
            @(negedge clk);
            p_iv = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            nchk++;
            if (p_ov !== 1'b1 || {p_s, p_e, p_f, p_sat, p_inx} !== exp_v) begin
                nerr++;
                $display("FAIL param25 in=%0d got=%b/%b exp=1/%b", x, p_ov,
                         {p_s, p_e, p_f, p_sat, p_inx}, exp_v);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", nerr, nchk);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_random();
        test_mid_reset();
        test_trunc();
        test_param();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
